// File: rtl/roll_sequencer.sv
// -----------------------------------------------------------------------------
// roll_sequencer
//
// Control sequencer for the dice roller's random-number datapath. A start
// pulse launches a roll: o_step strobes advance the random generator, first
// PERIOD_INIT cycles apart. After every STEPS_PER_STAGE strobes the spacing
// grows by PERIOD_STEP, so the roll slows down. The roll ends on its own once
// the next period would exceed PERIOD_MAX. A capture pulse ends it early.
// Runs on the divided slow clock. Every control input and output is a
// one-cycle pulse.
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset (aborts a roll, no o_done)
//   i_start      pulse: begin a roll, or restart one that is running
//   i_capture    pulse: stop the roll now and record the value (ROLL only)
//   i_set        pulse: load the current value as lucky number (IDLE only)
//   o_step       strobe: random generator advances one value
//   o_capture    strobe: push current value into history
//   o_set_lucky  strobe: lucky register loads current value
//   o_done       pulse: roll finished (natural end or capture)
//   o_busy       high while rolling
//   o_period     period of the current stage, 0 when not rolling
// -----------------------------------------------------------------------------
module roll_sequencer #(
    parameter int CW              = 8,
    parameter int PERIOD_INIT     = 1,
    parameter int PERIOD_STEP     = 1,
    parameter int STEPS_PER_STAGE = 4,
    parameter int PERIOD_MAX      = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_capture,
    input  logic          i_set,
    output logic          o_step,
    output logic          o_capture,
    output logic          o_set_lucky,
    output logic          o_done,
    output logic          o_busy,
    output logic [CW-1:0] o_period
);

    localparam int SW = (STEPS_PER_STAGE > 1) ? $clog2(STEPS_PER_STAGE) : 1;

    localparam logic [CW-1:0] ONE_C         = CW'(1);
    localparam logic [CW-1:0] PERIOD_INIT_C = CW'(PERIOD_INIT);
    localparam logic [CW:0]   PERIOD_STEP_C = (CW+1)'(PERIOD_STEP);
    localparam logic [CW:0]   PERIOD_MAX_C  = (CW+1)'(PERIOD_MAX);
    localparam logic [SW-1:0] STAGE_LAST_C  = SW'(STEPS_PER_STAGE - 1);
    localparam logic [SW-1:0] STAGE_ONE_C   = SW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [SW-1:0] stage_q,     stage_d;
    logic [CW-1:0] period_q,    period_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic          capture_q,   capture_d;
    logic          set_lucky_q, set_lucky_d;

    logic          step_hit;
    logic [CW:0]   next_period;

    // Strobe when the interval counter reaches the end of the current period.
    // Gated by busy so that the zero period outside a roll cannot alias to a
    // match.
    assign step_hit    = busy_q && (cnt_q == (period_q - ONE_C));
    // One extra bit so that a sum that overflows CW bits still compares above
    // PERIOD_MAX.
    assign next_period = {1'b0, period_q} + PERIOD_STEP_C;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so that no path
        // through the case below leaves one unassigned and infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        period_d    = period_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        capture_d   = 1'b0;
        set_lucky_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                set_lucky_d = i_set;
                if (i_start) begin
                    state_d  = ST_ROLL;
                    cnt_d    = '0;
                    stage_d  = '0;
                    period_d = PERIOD_INIT_C;
                    busy_d   = 1'b1;
                end
            end

            ST_ROLL: begin
                if (i_capture || (!i_start && step_hit && stage_q == STAGE_LAST_C
                                  && next_period > PERIOD_MAX_C)) begin
                    // Capture wins over a simultaneous start. A natural end
                    // happens when the stage finishes and the widened period
                    // would no longer be legal.
                    state_d   = ST_DONE;
                    capture_d = i_capture;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    stage_d   = '0;
                    period_d  = '0;
                end else if (i_start) begin
                    cnt_d    = '0;
                    stage_d  = '0;
                    period_d = PERIOD_INIT_C;
                end else if (step_hit) begin
                    cnt_d = '0;
                    if (stage_q == STAGE_LAST_C) begin
                        stage_d  = '0;
                        period_d = next_period[CW-1:0];
                    end else begin
                        stage_d = stage_q + STAGE_ONE_C;
                    end
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                stage_d  = '0;
                period_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stage_q     <= '0;
            period_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            capture_q   <= 1'b0;
            set_lucky_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            period_q    <= period_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            capture_q   <= capture_d;
            set_lucky_q <= set_lucky_d;
        end
    end

    assign o_step      = step_hit;
    assign o_capture   = capture_q;
    assign o_set_lucky = set_lucky_q;
    assign o_done      = done_q;
    assign o_busy      = busy_q;
    assign o_period    = period_q;

endmodule

// File: tb/tb_roll_sequencer.sv
// -----------------------------------------------------------------------------
// tb_roll_sequencer
//
// Drives roll_sequencer with directed pulse sequences, then with random
// start/capture/set pulses and occasional asynchronous resets. Every cycle
// the outputs are compared against a reference model. The model tracks a
// roll as a mode plus the number of cycles elapsed since the start. Period
// and step timing are derived arithmetically from the stage schedule.
// -----------------------------------------------------------------------------
module tb_roll_sequencer;

    localparam int CW       = 8;
    localparam int P_INIT   = 1;
    localparam int P_STEP   = 1;
    localparam int N_STEPS  = 4;
    localparam int P_MAX    = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          capture;
    logic          set;
    logic          step;
    logic          cap_o;
    logic          lucky_o;
    logic          done;
    logic          busy;
    logic [CW-1:0] period;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    // Reference model state: 0 idle, 1 rolling, 2 done.
    int m_mode  = 0;
    int m_e     = 0;
    bit m_cap   = 1'b0;
    bit m_lucky = 1'b0;

    // Observation counters for the directed full roll.
    int n_step = 0;
    int n_busy = 0;

    roll_sequencer #(
        .CW              (CW),
        .PERIOD_INIT     (P_INIT),
        .PERIOD_STEP     (P_STEP),
        .STEPS_PER_STAGE (N_STEPS),
        .PERIOD_MAX      (P_MAX)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_capture   (capture),
        .i_set       (set),
        .o_step      (step),
        .o_capture   (cap_o),
        .o_set_lucky (lucky_o),
        .o_done      (done),
        .o_busy      (busy),
        .o_period    (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cycle_no, got, exp);
        end
    endtask

    // Total ROLL cycles for an uninterrupted roll.
    function automatic int roll_len();
        int total = 0;
        for (int s = 0; s < 256; s++) begin
            int p;
            p = P_INIT + s * P_STEP;
            if (p > P_MAX) break;
            total += N_STEPS * p;
        end
        return total;
    endfunction

    // Period and step flag for the ROLL cycle e counted from the start.
    function automatic void sched(input int e, output int per, output bit stp);
        int rem;
        rem = e;
        per = 0;
        stp = 1'b0;
        for (int s = 0; s < 256; s++) begin
            int p;
            p = P_INIT + s * P_STEP;
            if (p > P_MAX) break;
            if (rem < N_STEPS * p) begin
                per = p;
                stp = ((rem % p) == p - 1);
                return;
            end
            rem -= N_STEPS * p;
        end
    endfunction

    task automatic compare_outputs();
        int per;
        bit stp;
        per = 0;
        stp = 1'b0;
        if (m_mode == 1) sched(m_e, per, stp);
        check("step",      int'(step),    int'(stp));
        check("busy",      int'(busy),    int'(m_mode == 1));
        check("period",    int'(period),  per);
        check("done",      int'(done),    int'(m_mode == 2));
        check("capture",   int'(cap_o),   int'(m_mode == 2 && m_cap));
        check("set_lucky", int'(lucky_o), int'(m_lucky));
        n_step += int'(step);
        n_busy += int'(busy);
    endtask

    task automatic model_step(input bit s, input bit c, input bit l);
        m_lucky = (m_mode == 0) && l;
        case (m_mode)
            0: begin
                if (s) begin
                    m_mode = 1;
                    m_e    = 0;
                end
            end
            1: begin
                if (c) begin
                    m_mode = 2;
                    m_cap  = 1'b1;
                end else if (s) begin
                    m_e = 0;
                end else if (m_e == roll_len() - 1) begin
                    m_mode = 2;
                    m_cap  = 1'b0;
                end else begin
                    m_e++;
                end
            end
            default: begin
                m_mode = 0;
                m_cap  = 1'b0;
            end
        endcase
    endtask

    // One clock cycle: check outputs, drive pulses away from the edge,
    // then advance the model at the active edge.
    task automatic cycle(input bit s, input bit c, input bit l);
        @(negedge clk);
        cycle_no++;
        compare_outputs();
        start   = s;
        capture = c;
        set     = l;
        @(posedge clk);
        model_step(s, c, l);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic reset_mid();
        @(negedge clk);
        cycle_no++;
        compare_outputs();
        start   = 1'b0;
        capture = 1'b0;
        set     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_step",   int'(step),    0);
        check("rst_busy",   int'(busy),    0);
        check("rst_period", int'(period),  0);
        check("rst_done",   int'(done),    0);
        check("rst_cap",    int'(cap_o),   0);
        check("rst_lucky",  int'(lucky_o), 0);
        m_mode  = 0;
        m_e     = 0;
        m_cap   = 1'b0;
        m_lucky = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        capture = 1'b0;
        set     = 1'b0;
        #12;
        check("reset_busy",   int'(busy),   0);
        check("reset_period", int'(period), 0);
        check("reset_step",   int'(step),   0);
        check("reset_done",   int'(done),   0);
        rst_n = 1'b1;

        // Full natural roll: 16 steps over 40 ROLL cycles, no capture.
        n_step = 0;
        n_busy = 0;
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(45);
        check("full_steps",  n_step, 16);
        check("full_cycles", n_busy, 40);

        // Capture ten cycles into a roll.
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(9);
        cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(4);

        // Restart in the middle of the third stage.
        n_step = 0;
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(15);
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(45);

        // Start and capture together, set ignored while rolling.
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(3);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(3);

        // Set and capture in IDLE, then start and set together.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(2);
        cycle(1'b1, 1'b0, 1'b1);
        idle_cycles(12);

        // Reset mid-roll, no o_done afterwards.
        reset_mid();
        idle_cycles(5);

        // Random pulses.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_mid();
            end else begin
                cycle($urandom_range(0, 39) == 0,
                      $urandom_range(0, 59) == 0,
                      $urandom_range(0, 9) == 0);
            end
        end
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
